e203_itcm_ram_banked: RTL



---
 rtl/e203_itcm_ram_banked.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/e203_itcm_ram_banked.sv
// Word-interleaved ITCM RAM banks behind one registered host port, plus a
// trap-vector fetch engine that borrows bank read slots ahead of the host.

module e203_itcm_ram_bank #(
    parameter int DW = 64,
    parameter int MW = DW / 8,
    parameter int RW = 15
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [RW-1:0] row,
    input  logic [MW-1:0] wem,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem [2**RW];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < MW; i++)
                if (wem[i]) mem[row][i*8 +: 8] <= wdat[i*8 +: 8];
        end else if (en) begin
            q <= mem[row];
        end
    end
endmodule

module e203_itcm_ram_banked #(
    parameter int DW    = 64,
    parameter int MW    = DW / 8,
    parameter int AW    = 16,
    parameter int BANKS = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [MW-1:0]   cmd_wem,
    input  logic [DW-1:0]   cmd_wdat,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdat,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            trap_bf_en,
    input  logic            trap_af_en,
    output logic            trap_busy,
    output logic            trap_done,
    output logic [XLEN-1:0] trap_data,
    output logic [XLEN-1:0] trap_data_bf,
    output logic [XLEN-1:0] trap_data_af
);
    localparam int LMW  = $clog2(MW);
    localparam int LXB  = $clog2(XLEN / 8);
    localparam int LB   = $clog2(BANKS);
    localparam int BW   = (LB > 0) ? LB : 1;
    localparam int RW   = AW - LB;
    localparam int BAW  = AW + LMW;
    // distance between neighbouring vector entries (4 bytes at XLEN=32)
    localparam int STEP = XLEN / 8;

    typedef enum logic [2:0] {IDLE, RD_BF, RD_VEC, RD_AF, WAIT, DONE} state_t;

    function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] w);
        return (LB == 0) ? '0 : BW'(w);
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] w);
        return RW'(w >> LB);
    endfunction

    state_t                        state, state_n, last_st;
    logic   [BAW-1:0]              tba_q, tba_cur;
    logic                          af_q;
    logic                          t_rd;
    logic   [AW-1:0]               t_word;
    logic   [LMW-1:0]              t_off, toff_q;
    logic   [BW-1:0]               t_bank, tbank_q;
    logic   [XLEN-1:0]             lane_dat;
    logic   [BW-1:0]               h_bank, rsp_bank_q;
    logic                          conflict, cmd_fire, up;
    logic                          rsp_fresh;
    logic   [DW-1:0]               rsp_q;
    logic   [BANKS-1:0]            b_en, b_we;
    logic   [BANKS-1:0][RW-1:0]    b_row;
    logic   [BANKS-1:0][DW-1:0]    bank_q;
    logic                          unused_trap_hi;

    assign unused_trap_hi = ^trap_addr[XLEN-1:BAW];

    always_comb begin
        state_n   = state;
        trap_busy = 1'b0;
        trap_done = 1'b0;
        t_rd      = 1'b0;
        case (state)
            IDLE:   if (trap_req) state_n = trap_bf_en ? RD_BF : RD_VEC;
            RD_BF:  begin t_rd = 1'b1; trap_busy = 1'b1; state_n = RD_VEC; end
            RD_VEC: begin t_rd = 1'b1; trap_busy = 1'b1; state_n = af_q ? RD_AF : WAIT; end
            RD_AF:  begin t_rd = 1'b1; trap_busy = 1'b1; state_n = WAIT; end
            WAIT:   begin trap_busy = 1'b1; state_n = DONE; end
            DONE:   begin trap_done = 1'b1; state_n = IDLE; end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tba_cur = tba_q;
        if (state == RD_BF) tba_cur = tba_q - BAW'(STEP);
        else if (state == RD_AF) tba_cur = tba_q + BAW'(STEP);
    end

    assign t_word = tba_cur[BAW-1:LMW];
    assign t_off  = tba_cur[LMW-1:0];
    assign t_bank = bank_of(t_word);

    // bank output of the previous cycle's trap read, narrowed to its lane
    assign lane_dat = XLEN'(bank_q[tbank_q] >> (XLEN * int'(toff_q >> LXB)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_st      <= IDLE;
            tba_q        <= '0;
            af_q         <= 1'b0;
            tbank_q      <= '0;
            toff_q       <= '0;
            trap_data    <= '0;
            trap_data_bf <= '0;
            trap_data_af <= '0;
        end else begin
            state   <= state_n;
            last_st <= state;
            tbank_q <= t_bank;
            toff_q  <= t_off;
            if (state == IDLE && trap_req) begin
                tba_q        <= trap_addr[BAW-1:0];
                af_q         <= trap_af_en;
                trap_data    <= '0;
                trap_data_bf <= '0;
                trap_data_af <= '0;
            end else begin
                case (last_st)
                    RD_BF:   trap_data_bf <= lane_dat;
                    RD_VEC:  trap_data    <= lane_dat;
                    RD_AF:   trap_data_af <= lane_dat;
                    default: ;
                endcase
            end
        end
    end

    // host port: the trap engine owns its bank for the cycle, so a same-bank
    // command (read or write) simply waits
    assign h_bank    = bank_of(cmd_addr);
    assign conflict  = t_rd && (h_bank == t_bank);
    assign cmd_ready = up && (!rsp_valid || rsp_ready) && !conflict;
    assign cmd_fire  = cmd_valid && cmd_ready;

    always_comb begin
        b_en  = '0;
        b_we  = '0;
        b_row = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (t_rd && t_bank == BW'(b)) begin
                b_en[b]  = 1'b1;
                b_row[b] = row_of(t_word);
            end else if (cmd_fire && h_bank == BW'(b)) begin
                b_en[b]  = 1'b1;
                b_we[b]  = cmd_we;
                b_row[b] = row_of(cmd_addr);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < BANKS; g++) begin : g_bank
            e203_itcm_ram_bank #(.DW(DW), .MW(MW), .RW(RW)) u_bank (
                .clk  (clk),
                .en   (b_en[g]),
                .we   (b_we[g]),
                .row  (b_row[g]),
                .wem  (cmd_wem),
                .wdat (cmd_wdat),
                .q    (bank_q[g])
            );
        end
    endgenerate

    // the bank register is only trusted in the first response cycle; later
    // trap reads may overwrite it, so a stalled response lives in rsp_q
    always_ff @(posedge clk) begin
        if (rst) begin
            up         <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_fresh  <= 1'b0;
            rsp_bank_q <= '0;
            rsp_q      <= '0;
        end else begin
            up <= 1'b1;
            if (rsp_fresh) rsp_q <= bank_q[rsp_bank_q];
            if (cmd_fire && !cmd_we) begin
                rsp_valid  <= 1'b1;
                rsp_fresh  <= 1'b1;
                rsp_bank_q <= h_bank;
            end else begin
                rsp_fresh <= 1'b0;
                if (rsp_ready) rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_rdat = rsp_fresh ? bank_q[rsp_bank_q] : rsp_q;
endmodule
